// File: rtl/soft_start_ramp.sv
// Soft-start duty ramp for a power stage: ramps the duty select up to a latched
// target in timed steps, holds it, and ramps down or hard-stops when enable drops.
module soft_start_ramp #(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned TS_W   = 10,
  parameter int unsigned CYC_W  = 7
) (
  input  logic              i_clk,
  input  logic              reset_n,
  input  logic              i_enable,
  input  logic              i_soft_stop,
  input  logic [DUTY_W-1:0] i_target,
  input  logic [DUTY_W-1:0] i_step,
  input  logic [TS_W-1:0]   i_ts_period,
  input  logic [CYC_W-1:0]  i_cycles_per_step,
  output logic [DUTY_W-1:0] o_duty_sel,
  output logic              o_enable,
  output logic              o_done,
  output logic              o_busy,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d, step_q, step_d;
  logic [TS_W-1:0]   per_q, per_d, pcnt_q, pcnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d, ccnt_q, ccnt_d;
  logic              en_q, en_d, done_q, done_d, busy_q, busy_d;

  logic              period_tick, step_evt, stay_ramp;
  logic [DUTY_W:0]   sum_up;
  logic [DUTY_W-1:0] duty_up, duty_dn;

  always_comb begin
    period_tick = (pcnt_q == per_q - TS_W'(1));
    step_evt    = period_tick && (ccnt_q == cyc_q - CYC_W'(1));
    sum_up      = {1'b0, duty_q} + {1'b0, step_q};
    duty_up     = (sum_up > {1'b0, tgt_q}) ? tgt_q : sum_up[DUTY_W-1:0];
    duty_dn     = (duty_q > step_q) ? (duty_q - step_q) : '0;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    per_d   = per_q;
    cyc_d   = cyc_q;

    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        if (i_enable) begin
          state_d = RAMP_UP;
          tgt_d   = i_target;
          // Zero-valued timing/step settings are stored as 1 so the counters always tick.
          step_d  = (i_step == '0)            ? DUTY_W'(1) : i_step;
          per_d   = (i_ts_period == '0)       ? TS_W'(1)   : i_ts_period;
          cyc_d   = (i_cycles_per_step == '0) ? CYC_W'(1)  : i_cycles_per_step;
        end
      end
      RAMP_UP: begin
        if (!i_enable) begin
          if (step_evt) duty_d = duty_up;
          if (i_soft_stop) begin
            state_d = RAMP_DOWN;
          end else begin
            state_d = IDLE;
            duty_d  = '0;
          end
        end else if (duty_q == tgt_q) begin
          state_d = HOLD;
        end else if (step_evt) begin
          duty_d = duty_up;
        end
      end
      HOLD: begin
        if (!i_enable) begin
          if (i_soft_stop) begin
            state_d = RAMP_DOWN;
          end else begin
            state_d = IDLE;
            duty_d  = '0;
          end
        end
      end
      RAMP_DOWN: begin
        // A pending step still lands on the edge where enable returns.
        if (i_enable) begin
          state_d = RAMP_UP;
          if (step_evt) duty_d = duty_dn;
        end else if (duty_q == '0) begin
          state_d = IDLE;
        end else if (step_evt) begin
          duty_d = duty_dn;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters run only while staying inside a ramp state; any entry restarts them.
  always_comb begin
    stay_ramp = (state_d == state_q) && ((state_q == RAMP_UP) || (state_q == RAMP_DOWN));
    pcnt_d    = '0;
    ccnt_d    = '0;
    if (stay_ramp) begin
      pcnt_d = period_tick ? '0 : (pcnt_q + TS_W'(1));
      if (period_tick) ccnt_d = step_evt ? '0 : (ccnt_q + CYC_W'(1));
      else             ccnt_d = ccnt_q;
    end
  end

  always_comb begin
    en_d   = (state_d != IDLE) && (duty_d != '0);
    done_d = (state_d == HOLD);
    busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      per_q   <= '0;
      cyc_q   <= '0;
      pcnt_q  <= '0;
      ccnt_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      per_q   <= per_d;
      cyc_q   <= cyc_d;
      pcnt_q  <= pcnt_d;
      ccnt_q  <= ccnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_duty_sel = duty_q;
  assign o_enable   = en_q;
  assign o_done     = done_q;
  assign o_busy     = busy_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_soft_start_ramp.sv
// Directed bench for soft_start_ramp: a table of ramp-up snapshots taken at fixed
// clock offsets from RAMP_UP entry, plus sequences for stop, re-enable and reset cases.
module tb_soft_start_ramp;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_enable;
  logic       i_soft_stop;
  logic [7:0] i_target;
  logic [7:0] i_step;
  logic [9:0] i_ts_period;
  logic [6:0] i_cycles_per_step;
  logic [7:0] o_duty_sel;
  logic       o_enable;
  logic       o_done;
  logic       o_busy;
  logic [1:0] o_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] step;
    logic [9:0] per;
    logic [6:0] cyc;
    int         t;
    logic [7:0] d;
    logic [1:0] s;
  } vec_t;

  vec_t vecs[26];
  int   nv = 0;

  soft_start_ramp #(.DUTY_W(8), .TS_W(10), .CYC_W(7)) dut (
    .i_clk             (clk),
    .reset_n           (reset_n),
    .i_enable          (i_enable),
    .i_soft_stop       (i_soft_stop),
    .i_target          (i_target),
    .i_step            (i_step),
    .i_ts_period       (i_ts_period),
    .i_cycles_per_step (i_cycles_per_step),
    .o_duty_sel        (o_duty_sel),
    .o_enable          (o_enable),
    .o_done            (o_done),
    .o_busy            (o_busy),
    .o_state           (o_state)
  );

  always #5 clk = ~clk;

  task automatic addv(input logic [7:0] tgt, input logic [7:0] step, input logic [9:0] per,
                      input logic [6:0] cyc, input int t, input logic [7:0] d, input logic [1:0] s);
    vecs[nv].tgt  = tgt;
    vecs[nv].step = step;
    vecs[nv].per  = per;
    vecs[nv].cyc  = cyc;
    vecs[nv].t    = t;
    vecs[nv].d    = d;
    vecs[nv].s    = s;
    nv++;
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [7:0] d, input logic [1:0] s);
    logic [2:0] fl;
    fl = {(s != 2'd0) && (d != 8'd0), (s == 2'd2), (s == 2'd1) || (s == 2'd3)};
    checks++;
    if ({o_duty_sel, o_state} !== {d, s}) begin
      errors++;
      $display("FAIL %s duty/state: got %0d/%0d expected %0d/%0d", nm, o_duty_sel, o_state, d, s);
    end
    checks++;
    if ({o_enable, o_done, o_busy} !== fl) begin
      errors++;
      $display("FAIL %s en/done/busy: got %b expected %b", nm, {o_enable, o_done, o_busy}, fl);
    end
  endtask

  // Reset, load settings, raise enable; returns 1 unit after the RAMP_UP entry edge.
  task automatic start_ramp(input logic [7:0] tgt, input logic [7:0] step,
                            input logic [9:0] per, input logic [6:0] cyc);
    reset_n     = 1'b0;
    i_enable    = 1'b0;
    i_soft_stop = 1'b0;
    clocks(1);
    reset_n           = 1'b1;
    i_target          = tgt;
    i_step            = step;
    i_ts_period       = per;
    i_cycles_per_step = cyc;
    i_enable          = 1'b1;
    clocks(1);
  endtask

  initial begin
    reset_n = 1'b1; i_enable = 1'b0; i_soft_stop = 1'b0;
    i_target = '0; i_step = '0; i_ts_period = '0; i_cycles_per_step = '0;

    addv(8'd4,   8'd1,   10'd10, 7'd5, 0,   8'd0,   2'd1);
    addv(8'd4,   8'd1,   10'd10, 7'd5, 49,  8'd0,   2'd1);
    addv(8'd4,   8'd1,   10'd10, 7'd5, 50,  8'd1,   2'd1);
    addv(8'd4,   8'd1,   10'd10, 7'd5, 100, 8'd2,   2'd1);
    addv(8'd4,   8'd1,   10'd10, 7'd5, 150, 8'd3,   2'd1);
    addv(8'd4,   8'd1,   10'd10, 7'd5, 199, 8'd3,   2'd1);
    addv(8'd4,   8'd1,   10'd10, 7'd5, 200, 8'd4,   2'd1);
    addv(8'd4,   8'd1,   10'd10, 7'd5, 201, 8'd4,   2'd2);
    addv(8'd10,  8'd4,   10'd10, 7'd5, 50,  8'd4,   2'd1);
    addv(8'd10,  8'd4,   10'd10, 7'd5, 100, 8'd8,   2'd1);
    addv(8'd10,  8'd4,   10'd10, 7'd5, 150, 8'd10,  2'd1);
    addv(8'd10,  8'd4,   10'd10, 7'd5, 151, 8'd10,  2'd2);
    addv(8'd10,  8'd4,   10'd10, 7'd5, 300, 8'd10,  2'd2);
    addv(8'd5,   8'd2,   10'd2,  7'd3, 5,   8'd0,   2'd1);
    addv(8'd5,   8'd2,   10'd2,  7'd3, 6,   8'd2,   2'd1);
    addv(8'd5,   8'd2,   10'd2,  7'd3, 12,  8'd4,   2'd1);
    addv(8'd5,   8'd2,   10'd2,  7'd3, 18,  8'd5,   2'd1);
    addv(8'd5,   8'd2,   10'd2,  7'd3, 19,  8'd5,   2'd2);
    addv(8'd3,   8'd0,   10'd0,  7'd0, 1,   8'd1,   2'd1);
    addv(8'd3,   8'd0,   10'd0,  7'd0, 3,   8'd3,   2'd1);
    addv(8'd3,   8'd0,   10'd0,  7'd0, 4,   8'd3,   2'd2);
    addv(8'd0,   8'd1,   10'd10, 7'd5, 0,   8'd0,   2'd1);
    addv(8'd0,   8'd1,   10'd10, 7'd5, 1,   8'd0,   2'd2);
    addv(8'd255, 8'd200, 10'd1,  7'd1, 1,   8'd200, 2'd1);
    addv(8'd255, 8'd200, 10'd1,  7'd1, 2,   8'd255, 2'd1);
    addv(8'd255, 8'd200, 10'd1,  7'd1, 3,   8'd255, 2'd2);

    // Reset takes effect between clock edges.
    #2 reset_n = 1'b0;
    #1 expect_out("reset_async", 8'd0, 2'd0);

    for (int i = 0; i < nv; i++) begin
      start_ramp(vecs[i].tgt, vecs[i].step, vecs[i].per, vecs[i].cyc);
      if (vecs[i].t > 0) clocks(vecs[i].t);
      expect_out($sformatf("vec%0d_t%0d", i, vecs[i].t), vecs[i].d, vecs[i].s);
    end

    // Soft stop from HOLD at duty 4.
    start_ramp(8'd4, 8'd1, 10'd10, 7'd5);
    clocks(201);
    expect_out("soft_hold", 8'd4, 2'd2);
    i_soft_stop = 1'b1; i_enable = 1'b0;
    clocks(1);  expect_out("soft_enter", 8'd4, 2'd3);
    clocks(49); expect_out("soft_49",    8'd4, 2'd3);
    clocks(1);  expect_out("soft_50",    8'd3, 2'd3);
    clocks(50); expect_out("soft_100",   8'd2, 2'd3);
    clocks(50); expect_out("soft_150",   8'd1, 2'd3);
    clocks(49); expect_out("soft_199",   8'd1, 2'd3);
    clocks(1);  expect_out("soft_200",   8'd0, 2'd3);
    clocks(1);  expect_out("soft_idle",  8'd0, 2'd0);

    // Hard stop mid-ramp at duty 2.
    start_ramp(8'd4, 8'd1, 10'd10, 7'd5);
    clocks(100);
    expect_out("hard_pre", 8'd2, 2'd1);
    i_soft_stop = 1'b0; i_enable = 1'b0;
    clocks(1);  expect_out("hard_stop", 8'd0, 2'd0);

    // Re-enable during ramp-down; new input settings must be ignored.
    start_ramp(8'd4, 8'd1, 10'd10, 7'd5);
    clocks(201);
    i_soft_stop = 1'b1; i_enable = 1'b0;
    clocks(1);
    clocks(100); expect_out("reen_down2", 8'd2, 2'd3);
    i_target = 8'd9; i_step = 8'd3; i_enable = 1'b1;
    clocks(1);  expect_out("reen_up",   8'd2, 2'd1);
    clocks(49); expect_out("reen_49",   8'd2, 2'd1);
    clocks(1);  expect_out("reen_50",   8'd3, 2'd1);
    clocks(50); expect_out("reen_100",  8'd4, 2'd1);
    clocks(1);  expect_out("reen_hold", 8'd4, 2'd2);

    // Enable falls on the same edge as a step event.
    start_ramp(8'd4, 8'd1, 10'd10, 7'd5);
    clocks(149);
    expect_out("coin_pre", 8'd2, 2'd1);
    i_soft_stop = 1'b1; i_enable = 1'b0;
    clocks(1);  expect_out("coin_edge", 8'd3, 2'd3);
    clocks(50); expect_out("coin_down", 8'd2, 2'd3);

    // Reset pulsed mid-ramp, then restart from IDLE.
    start_ramp(8'd4, 8'd1, 10'd10, 7'd5);
    clocks(120);
    expect_out("rst_pre", 8'd2, 2'd1);
    reset_n = 1'b0;
    #2 expect_out("rst_async", 8'd0, 2'd0);
    clocks(1);  expect_out("rst_held", 8'd0, 2'd0);
    reset_n = 1'b1;
    clocks(1);  expect_out("rst_restart", 8'd0, 2'd1);
    clocks(50); expect_out("rst_step1",   8'd1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
